// File: rtl/alu_issuer_pkg.sv
// Shared types for the ALU issuer: operator encoding, FSM states and funct3 constants.
package alu_issuer_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
    } alu_op;

    typedef enum logic [2:0] {IDLE, SETUP, REQ, WAIT, RESP} issuer_state_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic is_compare(input alu_op op);
        return op inside {ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Decode-side request, ALU-side request and result handshake bundle of the ALU issuer.
interface alu_issuer_if;
    import alu_issuer_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        is_imm;
    logic        is_branch;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        alu_req;
    alu_op       alu_operator;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_illegal;
    logic        out_taken;

    modport slave (
        input  in_valid, funct3, funct7b5, is_imm, is_branch, rs1, rs2, imm,
               alu_result, out_ready,
        output in_ready, alu_req, alu_operator, alu_op_a, alu_op_b,
               out_valid, out_result, out_illegal, out_taken
    );

    modport master (
        output in_valid, funct3, funct7b5, is_imm, is_branch, rs1, rs2, imm,
               alu_result, out_ready,
        input  in_ready, alu_req, alu_operator, alu_op_a, alu_op_b,
               out_valid, out_result, out_illegal, out_taken
    );

endinterface

// File: rtl/alu_issuer_decoder.sv
// Combinational RV32I OP/OP-IMM (and optional branch) funct3/funct7 decode to alu_op.
// Branch decoding is present only when ALU_ISSUE_BRANCH_EN is defined.
module alu_op_decoder
    import alu_issuer_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_imm,
    input  logic       is_branch,
    output alu_op      op,
    output logic       use_imm,
    output logic       illegal
);

    logic branch_sel;

`ifdef ALU_ISSUE_BRANCH_EN
    assign branch_sel = is_branch;
`else
    logic unused_branch;
    assign unused_branch = is_branch;
    assign branch_sel    = 1'b0;
`endif

    always_comb begin
        op      = ALU_ADD;
        use_imm = is_imm;
        illegal = 1'b0;
        if (branch_sel) begin
            use_imm = 1'b0;
            case (funct3)
                F3_BEQ:  op = ALU_EQ;
                F3_BNE:  op = ALU_NE;
                F3_BLT:  op = ALU_LT;
                F3_BGE:  op = ALU_GE;
                F3_BLTU: op = ALU_LTU;
                F3_BGEU: op = ALU_GEU;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_ADD:  op = (!is_imm && funct7b5) ? ALU_SUB : ALU_ADD;
                F3_SLL:  op = ALU_SLL;
                F3_SLT:  op = ALU_SLT;
                F3_SLTU: op = ALU_SLTU;
                F3_XOR:  op = ALU_XOR;
                F3_SR:   op = funct7b5 ? ALU_SRA : ALU_SRL;
                F3_OR:   op = ALU_OR;
                default: op = ALU_AND;
            endcase
            // bit 30 is only meaningful for shift-right and register SUB
            illegal = funct7b5 && (funct3 != F3_SR) && !(funct3 == F3_ADD && !is_imm);
        end
    end

endmodule

// File: rtl/alu_issuer.sv
// ALU request initiator: decode, present operands, strobe, settle, capture, return result.
// Optional branch-compare support with ALU_ISSUE_BRANCH_EN.
module alu_issuer
    import alu_issuer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_issuer_if.slave bus
);

    if (SETTLE_CYCLES == 0) begin : g_bad_settle
        $error("alu_issuer: SETTLE_CYCLES must be at least 1");
    end

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

    issuer_state_e state, state_d;
    alu_op         dec_op;
    logic          dec_use_imm;
    logic          dec_illegal;
    logic [CW-1:0] cnt;
    alu_op         operator_q;
    logic [31:0]   op_a_q;
    logic [31:0]   op_b_q;
    logic [31:0]   result_q;
    logic          illegal_q;
    logic          in_ready;
    logic          alu_req;
    logic          out_valid;

    alu_op_decoder u_dec (
        .funct3    (bus.funct3),
        .funct7b5  (bus.funct7b5),
        .is_imm    (bus.is_imm),
        .is_branch (bus.is_branch),
        .op        (dec_op),
        .use_imm   (dec_use_imm),
        .illegal   (dec_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        alu_req   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = dec_illegal ? RESP : SETUP;
            end
            SETUP: state_d = REQ;
            REQ: begin
                alu_req = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (cnt == '0) state_d = RESP;
            RESP: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            operator_q <= ALU_ADD;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            illegal_q  <= 1'b0;
            cnt        <= '0;
        end else begin
            // illegal requests leave the ALU-facing registers untouched
            if (state == IDLE && bus.in_valid) begin
                illegal_q <= dec_illegal;
                if (dec_illegal) begin
                    result_q <= '0;
                end else begin
                    operator_q <= dec_op;
                    op_a_q     <= bus.rs1;
                    op_b_q     <= dec_use_imm ? bus.imm : bus.rs2;
                end
            end
            if (state == REQ)                    cnt <= CW'(SETTLE_CYCLES - 1);
            else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0) result_q <= bus.alu_result;
        end
    end

`ifdef ALU_ISSUE_BRANCH_EN
    logic taken_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            taken_q <= 1'b0;
        else if (state == IDLE && bus.in_valid)
            taken_q <= 1'b0;
        else if (state == WAIT && cnt == '0)
            taken_q <= is_compare(operator_q) & bus.alu_result[0];
    end
    assign bus.out_taken = taken_q;
`else
    assign bus.out_taken = 1'b0;
`endif

    assign bus.in_ready     = in_ready;
    assign bus.alu_req      = alu_req;
    assign bus.out_valid    = out_valid;
    assign bus.alu_operator = operator_q;
    assign bus.alu_op_a     = op_a_q;
    assign bus.alu_op_b     = op_b_q;
    assign bus.out_result   = result_q;
    assign bus.out_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer with a behavioural ALU that captures on alu_req.
module tb_alu_issuer;
    import alu_issuer_pkg::*;

    localparam int unsigned SETTLE = 2;

    typedef struct {
        logic [31:0] result;
        logic        illegal;
        logic        taken;
        alu_op       op;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   req_count = 0;
    exp_t sb[$];

    alu_issuer_if bus ();

    alu_issuer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural ALU: result settles right after the capture strobe
    always @(posedge bus.alu_req) begin
        req_count++;
        case (bus.alu_operator)
            ALU_ADD:  bus.alu_result = bus.alu_op_a + bus.alu_op_b;
            ALU_SUB:  bus.alu_result = bus.alu_op_a - bus.alu_op_b;
            ALU_SLL:  bus.alu_result = bus.alu_op_a << bus.alu_op_b[4:0];
            ALU_SLT:  bus.alu_result = {31'd0, $signed(bus.alu_op_a) < $signed(bus.alu_op_b)};
            ALU_SLTU: bus.alu_result = {31'd0, bus.alu_op_a < bus.alu_op_b};
            ALU_XOR:  bus.alu_result = bus.alu_op_a ^ bus.alu_op_b;
            ALU_SRL:  bus.alu_result = bus.alu_op_a >> bus.alu_op_b[4:0];
            ALU_SRA:  bus.alu_result = $unsigned($signed(bus.alu_op_a) >>> bus.alu_op_b[4:0]);
            ALU_OR:   bus.alu_result = bus.alu_op_a | bus.alu_op_b;
            ALU_AND:  bus.alu_result = bus.alu_op_a & bus.alu_op_b;
            ALU_EQ:   bus.alu_result = {31'd0, bus.alu_op_a == bus.alu_op_b};
            ALU_NE:   bus.alu_result = {31'd0, bus.alu_op_a != bus.alu_op_b};
            ALU_LT:   bus.alu_result = {31'd0, $signed(bus.alu_op_a) < $signed(bus.alu_op_b)};
            ALU_GE:   bus.alu_result = {31'd0, $signed(bus.alu_op_a) >= $signed(bus.alu_op_b)};
            ALU_LTU:  bus.alu_result = {31'd0, bus.alu_op_a < bus.alu_op_b};
            default:  bus.alu_result = {31'd0, bus.alu_op_a >= bus.alu_op_b};
        endcase
    end

    function automatic exp_t model(input logic [2:0] f3, input logic f7, input logic imm_sel,
                                   input logic br, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] im);
        exp_t        e;
        logic [31:0] y;
        y = imm_sel ? im : b;
        e.result = '0;
        e.illegal = 1'b0;
        e.taken = 1'b0;
        e.op = ALU_ADD;
`ifdef ALU_ISSUE_BRANCH_EN
        if (br) begin
            case (f3)
                3'd0: begin e.op = ALU_EQ;  e.result[0] = (a == b); end
                3'd1: begin e.op = ALU_NE;  e.result[0] = (a != b); end
                3'd4: begin e.op = ALU_LT;  e.result[0] = ($signed(a) < $signed(b)); end
                3'd5: begin e.op = ALU_GE;  e.result[0] = ($signed(a) >= $signed(b)); end
                3'd6: begin e.op = ALU_LTU; e.result[0] = (a < b); end
                3'd7: begin e.op = ALU_GEU; e.result[0] = (a >= b); end
                default: e.illegal = 1'b1;
            endcase
            e.taken = e.result[0];
            return e;
        end
`else
        if (br) e.taken = 1'b0;
`endif
        if (f7 && f3 != 3'd5 && !(f3 == 3'd0 && !imm_sel)) begin
            e.illegal = 1'b1;
            return e;
        end
        case (f3)
            3'd0: if (f7) begin e.op = ALU_SUB; e.result = a - y; end
                  else    begin e.op = ALU_ADD; e.result = a + y; end
            3'd1: begin e.op = ALU_SLL;  e.result = a << y[4:0]; end
            3'd2: begin e.op = ALU_SLT;  e.result = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0; end
            3'd3: begin e.op = ALU_SLTU; e.result = (a < y) ? 32'd1 : 32'd0; end
            3'd4: begin e.op = ALU_XOR;  e.result = a ^ y; end
            3'd5: if (f7) begin e.op = ALU_SRA; e.result = $unsigned($signed(a) >>> y[4:0]); end
                  else    begin e.op = ALU_SRL; e.result = a >> y[4:0]; end
            3'd6: begin e.op = ALU_OR;   e.result = a | y; end
            default: begin e.op = ALU_AND; e.result = a & y; end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drives one request for one accepting edge; returns one cycle after acceptance
    task automatic send_op(input logic [2:0] f3, input logic f7, input logic imm_sel,
                           input logic br, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im);
        sb.push_back(model(f3, f7, imm_sel, br, a, b, im));
        for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        bus.is_imm = imm_sel;
        bus.is_branch = br;
        bus.rs1 = a;
        bus.rs2 = b;
        bus.imm = im;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if ({bus.in_ready, bus.alu_req, bus.out_valid, bus.out_illegal, bus.out_taken} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 10000",
                     {bus.in_ready, bus.alu_req, bus.out_valid, bus.out_illegal, bus.out_taken});
        end
        vectors++;
        if (bus.alu_operator !== ALU_ADD || bus.alu_op_a !== '0 || bus.alu_op_b !== '0 || bus.out_result !== '0) begin
            miscompares++;
            $display("FAIL reset_data: op=%0d a=%h b=%h res=%h expected ADD/0/0/0",
                     bus.alu_operator, bus.alu_op_a, bus.alu_op_b, bus.out_result);
        end
    endtask

    task automatic test_latency();
        exp_t       e;
        int         r0;
        logic [5:1] req_seen;
        logic [5:1] val_seen;
        r0 = req_count;
        send_op(3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            req_seen[c] = bus.alu_req;
            val_seen[c] = bus.out_valid;
            if (c < 5) tick();
        end
        vectors++;
        if (req_seen !== 5'b00010) begin
            miscompares++;
            $display("FAIL lat_req: cycles5..1 got %b expected 00010", req_seen);
        end
        vectors++;
        if (val_seen !== 5'b10000) begin
            miscompares++;
            $display("FAIL lat_valid: cycles5..1 got %b expected 10000", val_seen);
        end
        e = sb.pop_front();
        vectors++;
        if (bus.out_result !== e.result || bus.out_result !== 32'd12) begin
            miscompares++;
            $display("FAIL add_result: got %h expected %h", bus.out_result, e.result);
        end
        vectors++;
        if (req_count - r0 != 1) begin
            miscompares++;
            $display("FAIL add_req_count: got %0d expected 1", req_count - r0);
        end
        handshake();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_return_idle: ready=%b valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_sub_illegal();
        exp_t e;
        bit   ok;
        int   r0;
        send_op(3'd0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0);
        wait_valid(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || bus.out_result !== e.result || bus.alu_operator !== ALU_SUB || bus.out_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL sub: valid=%b res=%h op=%0d ill=%b expected 1/%h/SUB/0",
                     ok, bus.out_result, bus.alu_operator, bus.out_illegal, e.result);
        end
        handshake();
        r0 = req_count;
        send_op(3'd0, 1'b1, 1'b1, 1'b0, 32'd9, 32'd9, 32'd9);
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_illegal !== e.illegal || bus.out_result !== e.result) begin
            miscompares++;
            $display("FAIL illegal_imm: valid=%b ill=%b res=%h expected 1/%b/%h",
                     bus.out_valid, bus.out_illegal, bus.out_result, e.illegal, e.result);
        end
        vectors++;
        if (bus.alu_operator !== ALU_SUB || bus.alu_op_a !== 32'd3 || bus.alu_op_b !== 32'd5 || req_count != r0) begin
            miscompares++;
            $display("FAIL illegal_hold: op=%0d a=%h b=%h reqs=%0d expected SUB/3/5/0",
                     bus.alu_operator, bus.alu_op_a, bus.alu_op_b, req_count - r0);
        end
        handshake();
    endtask

    task automatic test_mix();
        exp_t        e;
        bit          ok;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] im;
        for (int unsigned k = 0; k < 10; k++) begin
            a = $urandom;
            b = $urandom;
            im = $urandom;
            if (k == 8) send_op(3'd5, 1'b1, 1'b1, 1'b0, 32'h8000_0000, b, 32'd4);
            else if (k == 9) send_op(3'd5, 1'b1, 1'b0, 1'b0, a, b, im);
            else send_op(3'(k), 1'b0, k[0], 1'b0, a, b, im);
            wait_valid(ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || bus.out_result !== e.result || bus.out_illegal !== 1'b0 || bus.alu_operator !== e.op) begin
                miscompares++;
                $display("FAIL mix%0d: valid=%b res=%h op=%0d expected %h op=%0d",
                         k, ok, bus.out_result, bus.alu_operator, e.result, e.op);
            end
            if (k == 8) begin
                vectors++;
                if (bus.out_result !== 32'hF800_0000) begin
                    miscompares++;
                    $display("FAIL srai: got %h expected f8000000", bus.out_result);
                end
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        bit          ok;
        logic [31:0] held;
        int          r0;
        send_op(3'd4, 1'b0, 1'b0, 1'b0, 32'h0F0F_1234, 32'hFFFF_0000, 32'd0);
        wait_valid(ok);
        held = bus.out_result;
        r0 = req_count;
        bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.in_valid = 1'b1;
        for (int unsigned c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== held || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall%0d: valid=%b res=%h ready=%b expected 1/%h/0",
                         c, bus.out_valid, bus.out_result, bus.in_ready, held);
            end
        end
        e = sb.pop_front();
        vectors++;
        if (!ok || held !== e.result) begin
            miscompares++;
            $display("FAIL stall_result: got %h expected %h", held, e.result);
        end
        bus.in_valid = 1'b0;
        handshake();
        tick();
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || req_count != r0) begin
            miscompares++;
            $display("FAIL stall_ignored: ready=%b valid=%b reqs=%0d expected 1/0/0",
                     bus.in_ready, bus.out_valid, req_count - r0);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        bus.out_ready = 1'b1;
        send_op(3'd6, 1'b0, 1'b1, 1'b0, 32'h00F0_0000, 32'd0, 32'h0000_000F);
        wait_valid(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || bus.out_result !== e.result || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL early_ready: valid=%b res=%h ready=%b expected 1/%h/0",
                     ok, bus.out_result, bus.in_ready, e.result);
        end
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL early_idle: ready=%b valid=%b expected 1/0", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen_valid;
        send_op(3'd0, 1'b0, 1'b0, 1'b0, 32'd100, 32'd200, 32'd0);
        void'(sb.pop_back());
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({bus.in_ready, bus.alu_req, bus.out_valid, bus.out_illegal, bus.out_taken} !== 5'b10000 ||
            bus.alu_operator !== ALU_ADD || bus.alu_op_a !== '0 || bus.alu_op_b !== '0 || bus.out_result !== '0) begin
            miscompares++;
            $display("FAIL midreset: ctrl=%b op=%0d a=%h b=%h res=%h expected 10000/ADD/0/0/0",
                     {bus.in_ready, bus.alu_req, bus.out_valid, bus.out_illegal, bus.out_taken},
                     bus.alu_operator, bus.alu_op_a, bus.alu_op_b, bus.out_result);
        end
        seen_valid = 1'b0;
        for (int unsigned c = 0; c < 8; c++) begin
            tick();
            seen_valid |= bus.out_valid;
        end
        vectors++;
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_novalid: got %b expected 0", seen_valid);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        bit   ok;
`ifdef ALU_ISSUE_BRANCH_EN
        logic [2:0] f3s[4] = '{3'd4, 3'd7, 3'd0, 3'd2};
        for (int unsigned k = 0; k < 4; k++) begin
            send_op(f3s[k], 1'b1, 1'b1, 1'b1, (k == 2) ? 32'd4 : 32'hFFFF_FFFF, (k == 2) ? 32'd5 : 32'd1, 32'd99);
            wait_valid(ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || bus.out_illegal !== e.illegal || bus.out_result !== e.result || bus.out_taken !== e.taken ||
                (!e.illegal && bus.alu_operator !== e.op)) begin
                miscompares++;
                $display("FAIL branch%0d: ill=%b res=%h taken=%b op=%0d expected %b/%h/%b/%0d",
                         k, bus.out_illegal, bus.out_result, bus.out_taken, bus.alu_operator,
                         e.illegal, e.result, e.taken, e.op);
            end
            handshake();
        end
`else
        send_op(3'd0, 1'b0, 1'b0, 1'b1, 32'd2, 32'd3, 32'd0);
        wait_valid(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || bus.out_result !== e.result || bus.alu_operator !== ALU_ADD || bus.out_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_ignored: res=%h op=%0d taken=%b expected %h/ADD/0",
                     bus.out_result, bus.alu_operator, bus.out_taken, e.result);
        end
        handshake();
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.funct3 = '0;
        bus.funct7b5 = 1'b0;
        bus.is_imm = 1'b0;
        bus.is_branch = 1'b0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        bus.imm = '0;
        bus.alu_result = '0;
        test_reset();
        test_latency();
        test_sub_illegal();
        test_mix();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_branch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
